mine_placer: RTL
================

Name: mine_placer

Overview:
- Parametrised successor to the fixed 8x8 mine placement engine.
- Places a requested number of mines at pseudo-random cells of a W x H mine board. Uses a seeded LFSR and rejects occupied cells.
- Optionally keeps a 3x3 safe zone mine-free around the first-click cell.
- Sits between the game controller (start/ack handshake) and the mine Board. It drives the Board write port; the adjacency Board increments neighbours from the same placeMineEn strobe.

Parameters:
- BOARD_WIDTH, 8, columns (2..64).
- BOARD_HEIGHT, 8, rows (2..64).
- LFSR_W, 16, LFSR width. Must be >= X_W+Y_W.
- MAX_RETRIES, 15, consecutive rejections before switching to linear-scan fallback.
- Derived: X_W=$clog2(BOARD_WIDTH), Y_W=$clog2(BOARD_HEIGHT), MINE_W=$clog2(BOARD_WIDTH*BOARD_HEIGHT+1), MAX_MINES=BOARD_WIDTH*BOARD_HEIGHT-9.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  begin placement; sampled only in INIT.
- ack  in  1  acknowledge completion; sampled only in DONE.
- totalMinesIn  in  MINE_W  requested mine count; latched on start.
- seed  in  LFSR_W  LFSR seed; latched on start (0 is replaced by 16'hACE1, truncated to LFSR_W).
- safeEn  in  1  enable safe zone; latched on start.
- safeX  in  X_W  safe-zone centre column; latched on start.
- safeY  in  Y_W  safe-zone centre row; latched on start.
- x  out  X_W  candidate/write column to Board.
- y  out  Y_W  candidate/write row to Board.
- mineBoardReadValue  in  1  combinational Board read of cell (x,y).
- placeMineEn  out  1  one-cycle write strobe; Board writes 1 at (x,y).
- minesPlaced  out  MINE_W  running count of placed mines.
- init, pick, check, place, done  out  1 each  one-hot state flags.

Behaviour:
- Reset (reset=0, async):
  - State goes to INIT.
  - x=0, y=0, placeMineEn=0, minesPlaced=0, retry count=0, fallback mode off.
  - Board contents are not cleared by this block.
- Reset mid-operation aborts immediately; any partial placement already written to the Board stays there.
- INIT:
  - init=1.
  - On start: latch target = min(totalMinesIn, MAX_MINES), LFSR seed, safeEn/safeX/safeY; clear minesPlaced.
  - If target==0, go to DONE; otherwise go to PICK.
- PICK (1 cycle):
  - Normal mode: LFSR advances one step. Register x = lfsr[X_W-1:0], y = lfsr[X_W+Y_W-1:X_W].
  - Fallback mode: x increments by 1. On x==BOARD_WIDTH-1, x wraps to 0 and y increments, wrapping to 0 after BOARD_HEIGHT-1. LFSR still advances.
  - Always go to CHECK.
- CHECK (1 cycle): reject if any of the following holds.
  - x>=BOARD_WIDTH or y>=BOARD_HEIGHT.
  - mineBoardReadValue==1.
  - safeEn and |x-safeX|<=1 and |y-safeY|<=1, evaluated as signed and unclipped at edges.
- On reject:
  - Retry count increments, saturating.
  - If retry count reaches MAX_RETRIES, set fallback mode.
  - Go to PICK.
- On accept: go to PLACE.
- PLACE (1 cycle):
  - placeMineEn=1 as a Moore output, with x/y held stable.
  - minesPlaced increments.
  - Retry count clears and fallback mode clears.
  - If minesPlaced+1==target, go to DONE; otherwise go to PICK.
- DONE:
  - done=1; x, y and minesPlaced are held.
  - On ack, go to INIT.
- Handshake rules:
  - start outside INIT and ack outside DONE are ignored.
  - start and ack asserted together have effect only in the state that samples them.
- Latency:
  - Best case 3 cycles per mine (PICK, CHECK, PLACE).
  - Termination is guaranteed because target<=MAX_MINES and fallback scan visits every cell.
- LFSR: Galois, taps 16'hB400 for LFSR_W=16. It never holds 0.
- Arithmetic: minesPlaced and target are MINE_W wide with no overflow, since target <= MAX_MINES.

Decomposition:
- Package mine_pkg holds:
  - state encoding localparams (INIT, PICK, CHECK, PLACE, DONE, one-hot);
  - LFSR tap constant 16'hB400;
  - default seed 16'hACE1;
  - safe-zone size constant (9).
- One sub-module: lfsr_galois (parameter WIDTH, TAPS), with ports clk, reset, load, loadValue, step, q.

Test Plan:
- totalMinesIn=10, seed=16'h1234, safeEn=0 on 8x8 -> exactly 10 placeMineEn pulses at distinct cells, minesPlaced=10, done=1; ack returns to INIT.
- totalMinesIn=0 -> DONE two cycles after start, no placeMineEn pulse, minesPlaced=0.
- safeEn=1, safeX=0, safeY=0, totalMinesIn=55 on 8x8 -> 55 mines placed; cells (0,0), (1,0), (0,1), (1,1) empty; fallback mode observed at least once.
- totalMinesIn=64 on 8x8 -> clamped to 55; minesPlaced=55.
- BOARD_WIDTH=5, BOARD_HEIGHT=6, totalMinesIn=8 -> every pulse has x<5 and y<6, all 8 distinct; out-of-range candidates are rejected in CHECK.
- reset pulled low during PLACE after 3 mines -> async return to INIT with all outputs at reset values; a new start with Board reset places the full count again.

Source files
------------

// File: rtl/mine_placer_pkg.sv
// ============================================================================
// mine_pkg : shared state encoding and constants for the mine placement engine
// Revision : 1.0
// ============================================================================
`default_nettype none

package mine_pkg;

  localparam logic [4:0] ST_INIT  = 5'b00001;
  localparam logic [4:0] ST_PICK  = 5'b00010;
  localparam logic [4:0] ST_CHECK = 5'b00100;
  localparam logic [4:0] ST_PLACE = 5'b01000;
  localparam logic [4:0] ST_DONE  = 5'b10000;

  typedef enum logic [4:0] {
    INIT  = ST_INIT,
    PICK  = ST_PICK,
    CHECK = ST_CHECK,
    PLACE = ST_PLACE,
    DONE  = ST_DONE
  } state_e;

  localparam logic [15:0] LFSR_TAPS       = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED    = 16'hACE1;
  localparam int          SAFE_ZONE_CELLS = 9;

endpackage

`default_nettype wire

// File: rtl/mine_placer_lfsr.sv
// ============================================================================
// lfsr_galois : right-shifting Galois LFSR with synchronous load and step
// Revision    : 1.0
// ============================================================================
`default_nettype none

module lfsr_galois
  import mine_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = loadValue;
    end else if (step) begin
      q_d = (q_q >> 1) ^ (q_q[0] ? TAPS : '0);
    end
  end

  // Reset to a non-zero value so the register can never lock up at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= WIDTH'(DEFAULT_SEED);
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/mine_placer.sv
// ============================================================================
// mine_placer : places N mines on a W x H board via LFSR picks, optional safe zone
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mine_placer
  import mine_pkg::*;
#(
  parameter int BOARD_WIDTH  = 8,
  parameter int BOARD_HEIGHT = 8,
  parameter int LFSR_W       = 16,
  parameter int MAX_RETRIES  = 15,
  localparam int X_W    = $clog2(BOARD_WIDTH),
  localparam int Y_W    = $clog2(BOARD_HEIGHT),
  localparam int MINE_W = $clog2(BOARD_WIDTH*BOARD_HEIGHT+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ack,
  input  logic [MINE_W-1:0] totalMinesIn,
  input  logic [LFSR_W-1:0] seed,
  input  logic              safeEn,
  input  logic [X_W-1:0]    safeX,
  input  logic [Y_W-1:0]    safeY,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  input  logic              mineBoardReadValue,
  output logic              placeMineEn,
  output logic [MINE_W-1:0] minesPlaced,
  output logic              init,
  output logic              pick,
  output logic              check,
  output logic              place,
  output logic              done
);

  localparam int                       MAX_MINES   = BOARD_WIDTH*BOARD_HEIGHT - SAFE_ZONE_CELLS;
  localparam int                       RETRY_W     = $clog2(MAX_RETRIES+1);
  localparam logic [MINE_W-1:0]        MAX_MINES_V = MINE_W'(MAX_MINES);
  localparam logic [X_W:0]             WIDTH_V     = (X_W+1)'(BOARD_WIDTH);
  localparam logic [Y_W:0]             HEIGHT_V    = (Y_W+1)'(BOARD_HEIGHT);
  localparam logic [X_W-1:0]           X_LAST      = X_W'(BOARD_WIDTH-1);
  localparam logic [Y_W-1:0]           Y_LAST      = Y_W'(BOARD_HEIGHT-1);
  localparam logic [RETRY_W-1:0]       RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0]       RETRY_SAT   = '1;
  localparam logic signed [X_W+1:0]    DX_ONE      = (X_W+2)'(1);
  localparam logic signed [Y_W+1:0]    DY_ONE      = (Y_W+2)'(1);
  localparam logic [LFSR_W-1:0]        TAPS_V      = LFSR_W'(LFSR_TAPS);

  state_e              state_q, state_d;
  logic [X_W-1:0]      x_q, x_d, safe_x_q, safe_x_d;
  logic [Y_W-1:0]      y_q, y_d, safe_y_q, safe_y_d;
  logic [MINE_W-1:0]   mines_q, mines_d, target_q, target_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                fallback_q, fallback_d, safe_en_q, safe_en_d;

  logic                w_lfsr_load, w_lfsr_step;
  logic [LFSR_W-1:0]   w_lfsr_q, w_seed;
  logic [MINE_W-1:0]   w_target;
  logic [RETRY_W-1:0]  w_retry_inc;
  logic signed [X_W+1:0] w_dx;
  logic signed [Y_W+1:0] w_dy;
  logic                w_in_zone, w_reject;

  lfsr_galois #(
    .WIDTH (LFSR_W),
    .TAPS  (TAPS_V)
  ) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .load      (w_lfsr_load),
    .loadValue (w_seed),
    .step      (w_lfsr_step),
    .q         (w_lfsr_q)
  );

  generate
    if (LFSR_W > X_W + Y_W) begin : g_unused_lfsr
      logic unused_lfsr_bits;
      assign unused_lfsr_bits = ^w_lfsr_q[LFSR_W-1:X_W+Y_W];
    end
  endgenerate

  assign w_seed      = (seed == '0) ? LFSR_W'(DEFAULT_SEED) : seed;
  assign w_target    = (totalMinesIn > MAX_MINES_V) ? MAX_MINES_V : totalMinesIn;
  assign w_retry_inc = (retry_q == RETRY_SAT) ? retry_q : retry_q + 1'b1;

  // Signed, unclipped distance so a corner centre still excludes only in-board cells.
  assign w_dx      = $signed({2'b00, x_q}) - $signed({2'b00, safe_x_q});
  assign w_dy      = $signed({2'b00, y_q}) - $signed({2'b00, safe_y_q});
  assign w_in_zone = safe_en_q && (w_dx >= -DX_ONE) && (w_dx <= DX_ONE)
                               && (w_dy >= -DY_ONE) && (w_dy <= DY_ONE);
  assign w_reject  = ({1'b0, x_q} >= WIDTH_V) || ({1'b0, y_q} >= HEIGHT_V)
                     || mineBoardReadValue || w_in_zone;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    mines_d     = mines_q;
    target_d    = target_q;
    retry_d     = retry_q;
    fallback_d  = fallback_q;
    safe_en_d   = safe_en_q;
    safe_x_d    = safe_x_q;
    safe_y_d    = safe_y_q;
    w_lfsr_load = 1'b0;
    w_lfsr_step = 1'b0;
    case (state_q)
      INIT: begin
        if (start) begin
          target_d    = w_target;
          w_lfsr_load = 1'b1;
          safe_en_d   = safeEn;
          safe_x_d    = safeX;
          safe_y_d    = safeY;
          mines_d     = '0;
          retry_d     = '0;
          fallback_d  = 1'b0;
          state_d     = (w_target == '0) ? DONE : PICK;
        end
      end
      PICK: begin
        w_lfsr_step = 1'b1;
        if (fallback_q) begin
          // Linear scan; >= also folds an out-of-range LFSR column back onto the board.
          if (x_q >= X_LAST) begin
            x_d = '0;
            y_d = (y_q >= Y_LAST) ? '0 : y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end else begin
          x_d = w_lfsr_q[X_W-1:0];
          y_d = w_lfsr_q[X_W+Y_W-1:X_W];
        end
        state_d = CHECK;
      end
      CHECK: begin
        if (w_reject) begin
          retry_d = w_retry_inc;
          if (w_retry_inc >= RETRY_LIMIT) begin
            fallback_d = 1'b1;
          end
          state_d = PICK;
        end else begin
          state_d = PLACE;
        end
      end
      PLACE: begin
        mines_d    = mines_q + 1'b1;
        retry_d    = '0;
        fallback_d = 1'b0;
        state_d    = ((mines_q + 1'b1) == target_q) ? DONE : PICK;
      end
      DONE: begin
        if (ack) begin
          state_d = INIT;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= INIT;
      x_q        <= '0;
      y_q        <= '0;
      mines_q    <= '0;
      target_q   <= '0;
      retry_q    <= '0;
      fallback_q <= 1'b0;
      safe_en_q  <= 1'b0;
      safe_x_q   <= '0;
      safe_y_q   <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      mines_q    <= mines_d;
      target_q   <= target_d;
      retry_q    <= retry_d;
      fallback_q <= fallback_d;
      safe_en_q  <= safe_en_d;
      safe_x_q   <= safe_x_d;
      safe_y_q   <= safe_y_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign minesPlaced = mines_q;
  assign placeMineEn = (state_q == PLACE);
  assign init        = (state_q == INIT);
  assign pick        = (state_q == PICK);
  assign check       = (state_q == CHECK);
  assign place       = (state_q == PLACE);
  assign done        = (state_q == DONE);

endmodule

`default_nettype wire
